// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side controller of the UART RX path. It detects the start-bit
//   falling edge and runs the per-bit oversampling counter (edge_cnt) and the
//   frame bit counter (bit_cnt). It strobes the start, parity and stop
//   checkers and the deserializer, and consumes their error flags. A clean
//   frame ends with a one-cycle data_valid pulse. A rejected frame ends with a
//   one-cycle frame_err pulse.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   rx_in        synchronized serial line, idle high
//   prescale     oversampling ratio (8, 16 or 32), latched at frame start
//   par_en       1 = frame carries a parity bit (sampled after the last data bit)
//   strt_glitch  registered start-check result
//   par_err      registered parity-check result
//   stp_err      registered stop-check result
//   edge_cnt     oversample index within the current bit
//   bit_cnt      bit index within the frame (0 = start)
//   dat_samp_en  data sampler enable, high whenever a frame is in progress
//   strt_chk_en  one-cycle start-check strobe
//   par_chk_en   one-cycle parity-check strobe
//   stp_chk_en   one-cycle stop-check strobe
//   deser_en     one-cycle shift strobe to the deserializer
//   data_valid   one-cycle frame-good pulse
//   frame_err    one-cycle frame-rejected pulse
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int prescale_w = 6,
  parameter int bit_cnt_w  = 4,
  parameter int frame_data = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [prescale_w-1:0] prescale,
  input  logic                  par_en,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [prescale_w-1:0] edge_cnt,
  output logic [bit_cnt_w-1:0]  bit_cnt,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid,
  output logic                  frame_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [prescale_w-1:0] p_lat;      // prescale frozen for the whole frame
  logic [prescale_w-1:0] edge_last;  // P-1: checker results valid, FSM decides
  logic [prescale_w-1:0] edge_chk;   // P-2: checker strobe point
  logic                  bit_end;

  assign edge_last = p_lat - prescale_w'(1);
  assign edge_chk  = p_lat - prescale_w'(2);
  assign bit_end   = (state != IDLE) && (edge_cnt == edge_last);

  // Strobes decode registered state only, so they are glitch-free and all
  // read 0 while the FSM sits in IDLE (including during reset).
  assign dat_samp_en = (state != IDLE);
  assign strt_chk_en = (state == START)  && (edge_cnt == edge_chk);
  assign par_chk_en  = (state == PARITY) && (edge_cnt == edge_chk);
  assign stp_chk_en  = (state == STOP)   && (edge_cnt == edge_chk);
  assign deser_en    = (state == DATA)   && bit_end;

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_in) state_nxt = START;
      START:   if (bit_end) state_nxt = strt_glitch ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == bit_cnt_w'(frame_data)))
                 state_nxt = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = par_err ? IDLE : STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      // NOTE: p_lat is reset like every other flop so the first frame never sees X.
      p_lat      <= prescale_w'(8);
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_nxt;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if ((state == IDLE) && !rx_in) p_lat <= prescale;

      // Counters stay at 0 in IDLE and restart from 0 on any return to IDLE.
      if ((state == IDLE) || (state_nxt == IDLE)) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + bit_cnt_w'(1);
      end else begin
        edge_cnt <= edge_cnt + prescale_w'(1);
      end

      // Terminal pulses are registered, so they show up in the first IDLE
      // cycle after the deciding edge.
      if (bit_end) begin
        case (state)
          START:   frame_err <= strt_glitch;
          PARITY:  frame_err <= par_err;
          STOP: begin
            data_valid <= !stp_err;
            frame_err  <= stp_err;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Self-checking bench for uart_rx_ctrl. Each frame is predicted cycle by
//   cycle from its own arithmetic. Cycle k after START entry belongs to bit k/P
//   at edge k%P. The frame length follows from the outcome of the frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int FD = 8;

  typedef struct packed {
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       samp;
    logic       strt;
    logic       par;
    logic       stp;
    logic       deser;
    logic       dv;
    logic       fe;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       deser_en;
  logic       data_valid;
  logic       frame_err;

  int vectors    = 0;
  int miscompares = 0;

  uart_rx_ctrl #(.prescale_w(6), .bit_cnt_w(4), .frame_data(FD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
            stp_chk_en, deser_en, data_valid, frame_err};
  endfunction

  function automatic logic [5:0] pick_p();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Expected outputs k cycles after START entry; k == frame length is the
  // first IDLE cycle, which carries the terminal pulse.
  function automatic obs_t model(int p, bit par, bit gl, bit pe, bit se, int k);
    obs_t o;
    int stop_bit, nbits, len, b, e;
    o        = '0;
    stop_bit = FD + 1 + (par ? 1 : 0);
    nbits    = gl ? 1 : ((par && pe) ? FD + 2 : stop_bit + 1);
    len      = nbits * p;
    b        = k / p;
    e        = k % p;
    if (k < len) begin
      o.edge_cnt = 6'(e);
      o.bit_cnt  = 4'(b);
      o.samp     = 1'b1;
      o.strt     = (b == 0) && (e == p - 2);
      o.deser    = (b >= 1) && (b <= FD) && (e == p - 1);
      o.par      = par && (b == FD + 1) && (e == p - 2);
      o.stp      = (b == stop_bit) && (e == p - 2);
    end else begin
      o.dv = !gl && !(par && pe) && !se;
      o.fe = !o.dv;
    end
    return o;
  endfunction

  // Runs one frame from the current IDLE cycle. Returns #1 after the edge
  // that shows the terminal pulse, or right after a reset if abort_k >= 0.
  task automatic run_frame(input string name, input int p, input bit par,
                           input logic [7:0] data, input bit gl, input bit pe,
                           input bit se, input int abort_k);
    int   stop_bit, nbits, len, b, e;
    obs_t got, exp;
    stop_bit = FD + 1 + (par ? 1 : 0);
    nbits    = gl ? 1 : ((par && pe) ? FD + 2 : stop_bit + 1);
    len      = nbits * p;
    rx_in    = 1'b0;
    prescale = 6'(p);
    par_en   = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int k = 0; k <= len; k++) begin
      exp = model(p, par, gl, pe, se, k);
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
      end
      if (k == abort_k) begin
        #2 rst = 1'b0;
        #1;
        got = sample();
        vectors++;
        if (got !== '0) begin
          miscompares++;
          $display("FAIL %s_rst_async got=%h exp=%h", name, got, obs_t'(0));
        end
        return;
      end
      if (k == len) begin
        rx_in       = 1'b1;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
      end else begin
        b = k / p;
        e = k % p;
        if (b == 0)                rx_in = 1'b0;
        else if (b <= FD)          rx_in = data[b - 1];
        else if (par && b == FD+1) rx_in = ^data;
        else                       rx_in = 1'b1;
        prescale = pick_p();
        // Checker flags and par_en only matter on their deciding cycle;
        // every other cycle they carry noise.
        par_en      = (b == FD && e == p - 1) ? par : 1'($urandom_range(0, 1));
        strt_glitch = (b == 0 && e == p - 1) ? gl : 1'($urandom_range(0, 1));
        par_err     = (par && b == FD + 1 && e == p - 1) ? pe : 1'($urandom_range(0, 1));
        stp_err     = (b == stop_bit && e == p - 1) ? se : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle_check(input string name, input int n);
    obs_t got;
    for (int i = 0; i < n; i++) begin
      rx_in    = 1'b1;
      prescale = pick_p();
      @(posedge clk); #1;
      got = sample();
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, got, obs_t'(0));
      end
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    #1;
    got = sample();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", got, obs_t'(0));
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    idle_check("reset_idle", 3);
  endtask

  task automatic test_clean_p8();
    run_frame("p8_clean", 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1);
    idle_check("p8_clean_idle", 2);
  endtask

  task automatic test_parity_p16();
    run_frame("p16_par", 16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    idle_check("p16_par_idle", 2);
  endtask

  task automatic test_start_glitch();
    run_frame("p8_glitch", 8, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, -1);
    idle_check("p8_glitch_idle", 2);
  endtask

  task automatic test_parity_err_p32();
    run_frame("p32_par_err", 32, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, -1);
    idle_check("p32_par_err_idle", 2);
  endtask

  task automatic test_stop_err();
    run_frame("p8_stp_err", 8, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, -1);
    idle_check("p8_stp_err_idle", 2);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_f1", 8, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, -1);
    run_frame("b2b_f2", 16, 1'b0, 8'hED, 1'b0, 1'b0, 1'b0, -1);
    idle_check("b2b_idle", 2);
  endtask

  task automatic test_reset_mid_frame();
    obs_t got;
    run_frame("rst_mid", 8, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 4 * 8 + 3);
    rx_in = 1'b1;
    @(posedge clk); #1;
    got = sample();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_held got=%h exp=%h", got, obs_t'(0));
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    idle_check("rst_mid_idle", 4);
  endtask

  task automatic test_random();
    int  p;
    bit  par, gl, pe, se;
    for (int f = 0; f < 30; f++) begin
      p   = int'(pick_p());
      par = 1'($urandom_range(0, 1));
      gl  = ($urandom_range(0, 7) == 0);
      pe  = par && ($urandom_range(0, 3) == 0);
      se  = ($urandom_range(0, 3) == 0);
      run_frame("rand", p, par, 8'($urandom), gl, pe, se, -1);
      if ($urandom_range(0, 1) == 1) idle_check("rand_idle", int'($urandom_range(1, 3)));
    end
    idle_check("rand_final_idle", 2);
  endtask

  initial begin
    test_reset();
    test_clean_p8();
    test_parity_p16();
    test_start_glitch();
    test_parity_err_p32();
    test_stop_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller of the UART RX path.
- Detects the start-bit falling edge and runs the per-bit oversampling edge counter and frame bit counter.
- Sequences the start, parity and stop checkers and the deserializer through one-cycle enable pulses, and consumes their error flags.
- Issues a one-cycle data_valid for a clean frame, or frame_err for a rejected one; sits between the RX input synchronizer/data sampler and the check/deserializer stages.

Parameters:
- prescale_w, 6, width of prescale input and edge counter
- bit_cnt_w, 4, width of bit counter
- frame_data, 8, data bits per frame

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rx_in  input  1  synchronized serial line, idle high
- prescale  input  prescale_w  oversampling ratio; legal values 8, 16, 32
- par_en  input  1  1 = frame carries a parity bit
- strt_glitch  input  1  registered start-check result
- par_err  input  1  registered parity-check result
- stp_err  input  1  registered stop-check result
- edge_cnt  output  prescale_w  oversample index within current bit
- bit_cnt  output  bit_cnt_w  bit index within frame
- dat_samp_en  output  1  enables data sampler
- strt_chk_en  output  1  one-cycle start-check strobe
- par_chk_en  output  1  one-cycle parity-check strobe
- stp_chk_en  output  1  one-cycle stop-check strobe
- deser_en  output  1  one-cycle shift strobe to deserializer
- data_valid  output  1  one-cycle frame-good pulse
- frame_err  output  1  one-cycle frame-rejected pulse

Behaviour:
- Reset: state IDLE; all outputs 0; latched prescale = 8.
- States:
  - IDLE, START, DATA, PARITY, STOP.
  - P denotes prescale latched on IDLE->START; prescale changes mid-frame are ignored.
- edge_cnt/bit_cnt:
  - Both are 0 in IDLE.
  - In other states edge_cnt increments every cycle, wrapping P-1 -> 0.
  - bit_cnt increments on each wrap.
  - bit_cnt = 0 is start, 1..frame_data is data, frame_data+1 is parity (if par_en), then stop.
- dat_samp_en = 1 in every state except IDLE.
- Strobe timing:
  - All check strobes fire at edge_cnt == P-2 of their bit.
  - Checker result is valid at edge_cnt == P-1; the FSM decides on that cycle.
- Transitions:
  - IDLE:
    - rx_in == 0 -> START next cycle with edge_cnt = 0, bit_cnt = 0.
    - Otherwise stay.
  - START:
    - strt_chk_en pulses at P-2.
    - At P-1: strt_glitch = 1 -> IDLE with frame_err pulse; else -> DATA.
  - DATA:
    - deser_en pulses at P-1 of each data bit.
    - After bit frame_data at P-1 -> PARITY if par_en, else STOP.
  - PARITY:
    - par_chk_en pulses at P-2.
    - At P-1: par_err -> IDLE with frame_err; else -> STOP.
  - STOP:
    - stp_chk_en pulses at P-2.
    - At P-1 -> IDLE.
    - data_valid = !stp_err, frame_err = stp_err; registered, visible the cycle after P-1.
- data_valid and frame_err are never both 1; each is a single-cycle pulse.
- Back-to-back frames:
  - If rx_in == 0 in the IDLE cycle that carries data_valid, the next cycle enters START.
  - No idle gap is required.
- par_en is sampled at the DATA->next transition only.
- Minimum legal prescale is 8; other values are unsupported and not checked by the bench.
- Reset mid-frame: immediate return to IDLE, counters 0, no pulses emitted.

Test Plan:
- P=8, par_en=0, frame 0xA5, checkers clean:
  - exactly 8 deser_en pulses, each at edge_cnt 7.
  - data_valid high one cycle, 80 cycles after START entry.
  - frame_err stays 0.
- P=16, par_en=1, frame 0x3C:
  - strt_chk_en at bit 0 / edge 14.
  - par_chk_en at bit 9 / edge 14.
  - stp_chk_en at bit 10 / edge 14.
  - data_valid after bit 10 / edge 15.
- P=8, strt_glitch=1 at bit 0 / edge 7:
  - frame_err pulse.
  - return to IDLE.
  - no deser_en, no data_valid.
- P=32, par_en=1, par_err=1:
  - frame_err pulse after bit 9.
  - stp_chk_en never asserted.
  - IDLE next cycle.
- P=8, two frames with rx_in low in the data_valid cycle:
  - second START entered the next cycle.
  - both frames produce data_valid.
  - prescale changed to 16 during frame 1 has no effect until frame 2.
- rst asserted at bit 4 of a frame:
  - all outputs 0 immediately.
  - after release with rx_in high, state remains IDLE.
